sw_input_capture: RTL and testbench
===================================

Name: sw_input_capture

Overview:
- Front-end stage between the raw board switches and the calculator core (`make17`) and the display selector (`disp_select`).
- Synchronizes and debounces the operator, operand and display-select switches.
- Turns the SW17 execute key into a clean one-shot capture event.
- Holds the captured operator/operand set stable for the core and flags when live switches diverge from the captured set.

Parameters:
- DIV, 50000: sample-tick period in CLK cycles; must be >= 2.
- STABLE_N, 4: consecutive equal samples required to change a debounced level; must be >= 2.

Ports:
- CLK  input  1  system clock
- RST_N  input  1  asynchronous active-low reset
- OPE_RAW  input  2  raw {SW1,SW2}
- A_RAW  input  4  raw {SW6,SW7,SW8,SW9}
- B_RAW  input  4  raw {SW12,SW13,SW14,SW15}
- DISP_RAW  input  2  raw {SW18,SW22}
- EXEC_RAW  input  1  raw SW17
- DISP  output  2  debounced display select (live)
- OPE_L  output  2  captured operator
- A_L  output  4  captured operand A
- B_L  output  4  captured operand B
- LOAD  output  1  one-cycle pulse; captured values are new this cycle
- VALID  output  1  at least one capture since reset
- DIRTY  output  1  live debounced OPE/A/B differ from the captured set

Behaviour:
- Clock and reset: single clock CLK. RST_N is asynchronous active-low; asserting it mid-operation aborts any debounce or capture immediately.
- Synchronizer: every raw bit passes through a 2-FF synchronizer. Synchronizer reset values are 0, except EXEC, which resets to 1.
- Prescaler:
  - Counts 0..DIV-1, wraps to 0, resets to 0.
  - TICK is high for the one cycle when count == DIV-1.
  - Between ticks, sampling is frozen.
- Debounce, per bit:
  - On each TICK, the synchronized value shifts into a STABLE_N-deep history.
  - If the history after the shift is all-1 or all-0, the debounced bit registers that value on the same edge.
  - Otherwise it holds.
  - A glitch lasting fewer than STABLE_N consecutive ticks never reaches the output.
- Debounce reset values:
  - All histories and debounced bits reset to 0.
  - Exception: EXEC history and debounced EXEC reset to all-1, so a key held through reset is treated as already pressed.
- DISP is the debounced DISP_RAW, not latched by the capture.
- Execute FSM, states IDLE, CAPTURE, HOLD; resets to HOLD:
  - HOLD: debounced EXEC == 0 -> IDLE; otherwise stay.
  - IDLE: debounced EXEC == 1 -> CAPTURE. On this same edge, OPE_L/A_L/B_L load the current debounced OPE/A/B, and VALID is set to 1.
  - CAPTURE: lasts exactly one cycle, then -> HOLD unconditionally.
- Capture consequences:
  - Because the FSM resets to HOLD, a key held through reset produces no capture until it has been released and pressed again.
  - Auto-repeat is impossible: one capture per press.
- LOAD: Moore output, 1 only in CAPTURE. OPE_L/A_L/B_L already carry the new values in that cycle.
- Captured registers: OPE_L/A_L/B_L reset to 0 and change only on the IDLE->CAPTURE edge. VALID resets to 0 and is never cleared except by reset.
- DIRTY: combinational, = VALID & ({OPE_db,A_db,B_db} != {OPE_L,A_L,B_L}).
  - DIRTY is 0 in the CAPTURE cycle.
  - DIRTY is 0 whenever VALID = 0.
- Simultaneous events:
  - If operands and EXEC stabilize on the same TICK, the capture takes the operand values debounced on that edge. The capture happens one edge later, in IDLE, and reads the updated registers.
  - An operand change that debounces during CAPTURE or HOLD is not captured and raises DIRTY.
- Reset mid-CAPTURE drops LOAD and VALID immediately, asynchronously.

Test Plan (DIV=4, STABLE_N=3 throughout):
1. Reset release with EXEC_RAW=0:
   - DEB EXEC reaches 0 on the 3rd TICK after the synchronized 0 arrives; FSM HOLD->IDLE.
   - LOAD, VALID and DIRTY stay 0 the entire time.
2. Capture:
   - OPE_RAW=2'b10, A_RAW=4'h7, B_RAW=4'h3, all stable, then EXEC_RAW=1 for 40 cycles.
   - Exactly one LOAD pulse.
   - In the LOAD cycle, OPE_L=2, A_L=7, B_L=3, VALID=1 and DIRTY=0.
3. Glitch rejection:
   - A_RAW=4'h7→4'hF for 6 cycles, then back to 4'h7.
   - Covers 1-2 TICKs only; debounced A and DIRTY unchanged.
   - EXEC_RAW pulse of 6 cycles produces no LOAD.
4. Dirty tracking:
   - After capture, B_RAW→4'h9 held.
   - DIRTY rises after 3 TICKs; B_L stays 3.
   - Release and re-press EXEC: new LOAD with B_L=9, and DIRTY returns to 0.
5. Held through reset:
   - EXEC_RAW=1 during and after RST_N release: no LOAD ever.
   - Release EXEC_RAW for at least 3 TICKs, then re-press: exactly one LOAD.
6. Async reset mid-operation:
   - Assert RST_N=0 in the CAPTURE cycle.
   - LOAD, VALID, OPE_L, A_L and B_L go to 0 without a clock edge; DISP=0.

Source files
------------

// File: rtl/sw_input_capture.sv
// Switch front end: 2-FF synchronizers, tick-sampled debouncers and a one-shot
// execute-key capture of the operator/operand set for the calculator core.
module sw_input_capture #(
  parameter int DIV      = 50000,
  parameter int STABLE_N = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [1:0] OPE_RAW,
  input  logic [3:0] A_RAW,
  input  logic [3:0] B_RAW,
  input  logic [1:0] DISP_RAW,
  input  logic       EXEC_RAW,
  output logic [1:0] DISP,
  output logic [1:0] OPE_L,
  output logic [3:0] A_L,
  output logic [3:0] B_L,
  output logic       LOAD,
  output logic       VALID,
  output logic       DIRTY
);

  localparam int NB       = 13;
  localparam int EXEC_BIT = 12;
  localparam int CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [NB-1:0] SYNC_RST = 13'h1000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  logic [NB-1:0] raw_s;
  logic [NB-1:0] sync1_r;
  logic [NB-1:0] sync2_r;
  logic [NB-1:0] deb_s;
  logic [CW-1:0] cnt_r;
  logic          tick_s;
  state_t        state_r;
  logic          load_r;
  logic          valid_r;
  logic [1:0]    ope_l_r;
  logic [3:0]    a_l_r;
  logic [3:0]    b_l_r;
  logic          exec_db_s;
  logic [1:0]    ope_db_s;
  logic [3:0]    a_db_s;
  logic [3:0]    b_db_s;

  assign raw_s = {EXEC_RAW, DISP_RAW, OPE_RAW, A_RAW, B_RAW};

  // Two-stage synchronizer; EXEC resets high so a held key looks pressed.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_r <= SYNC_RST;
      sync2_r <= SYNC_RST;
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
    end
  end

  // Sample-tick prescaler, counting 0..DIV-1.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_r <= '0;
    end else if (tick_s) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign tick_s = (cnt_r == CW'(DIV - 1));

  for (genvar i = 0; i < NB; i++) begin : g_deb
    localparam logic RST_BIT = (i == EXEC_BIT) ? 1'b1 : 1'b0;
    logic [STABLE_N-1:0] hist_r;
    logic [STABLE_N-1:0] shift_s;
    logic                deb_bit_r;

    assign shift_s = {hist_r[STABLE_N-2:0], sync2_r[i]};

    // Level changes only once the post-shift history is unanimous.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        hist_r    <= {STABLE_N{RST_BIT}};
        deb_bit_r <= RST_BIT;
      end else if (tick_s) begin
        hist_r <= shift_s;
        if (&shift_s) begin
          deb_bit_r <= 1'b1;
        end else if (~|shift_s) begin
          deb_bit_r <= 1'b0;
        end else begin
          deb_bit_r <= deb_bit_r;
        end
      end else begin
        hist_r    <= hist_r;
        deb_bit_r <= deb_bit_r;
      end
    end

    assign deb_s[i] = deb_bit_r;
  end

  assign exec_db_s = deb_s[EXEC_BIT];
  assign DISP      = deb_s[11:10];
  assign ope_db_s  = deb_s[9:8];
  assign a_db_s    = deb_s[7:4];
  assign b_db_s    = deb_s[3:0];

  // Execute FSM; starting in HOLD forces a release before the first capture.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= ST_HOLD;
      load_r  <= 1'b0;
      valid_r <= 1'b0;
      ope_l_r <= 2'b00;
      a_l_r   <= 4'h0;
      b_l_r   <= 4'h0;
    end else begin
      case (state_r)
        ST_HOLD: begin
          load_r <= 1'b0;
          if (!exec_db_s) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_HOLD;
          end
        end
        ST_IDLE: begin
          if (exec_db_s) begin
            state_r <= ST_CAPTURE;
            load_r  <= 1'b1;
            valid_r <= 1'b1;
            ope_l_r <= ope_db_s;
            a_l_r   <= a_db_s;
            b_l_r   <= b_db_s;
          end else begin
            state_r <= ST_IDLE;
            load_r  <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          state_r <= ST_HOLD;
          load_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_HOLD;
          load_r  <= 1'b0;
        end
      endcase
    end
  end

  assign LOAD  = load_r;
  assign VALID = valid_r;
  assign OPE_L = ope_l_r;
  assign A_L   = a_l_r;
  assign B_L   = b_l_r;
  assign DIRTY = valid_r & ({ope_db_s, a_db_s, b_db_s} != {ope_l_r, a_l_r, b_l_r});

endmodule

// File: tb/tb_sw_input_capture.sv
// Directed bench for sw_input_capture with DIV=4, STABLE_N=3.
module tb_sw_input_capture;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [1:0] OPE_RAW;
  logic [3:0] A_RAW;
  logic [3:0] B_RAW;
  logic [1:0] DISP_RAW;
  logic       EXEC_RAW;
  logic [1:0] DISP;
  logic [1:0] OPE_L;
  logic [3:0] A_L;
  logic [3:0] B_L;
  logic       LOAD;
  logic       VALID;
  logic       DIRTY;

  int errors = 0;
  int checks = 0;

  int         load_cnt = 0;
  logic       seen_valid = 1'b0;
  logic       seen_dirty = 1'b0;
  logic [1:0] snap_ope;
  logic [3:0] snap_a;
  logic [3:0] snap_b;
  logic       snap_valid;
  logic       snap_dirty;

  sw_input_capture #(.DIV(4), .STABLE_N(3)) dut (
    .CLK(CLK), .RST_N(RST_N), .OPE_RAW(OPE_RAW), .A_RAW(A_RAW), .B_RAW(B_RAW),
    .DISP_RAW(DISP_RAW), .EXEC_RAW(EXEC_RAW), .DISP(DISP), .OPE_L(OPE_L),
    .A_L(A_L), .B_L(B_L), .LOAD(LOAD), .VALID(VALID), .DIRTY(DIRTY)
  );

  always #5 CLK = ~CLK;

  // Output monitor sampled on the inactive edge.
  always @(negedge CLK) begin
    if (VALID) seen_valid = 1'b1;
    if (DIRTY) seen_dirty = 1'b1;
    if (LOAD) begin
      load_cnt   = load_cnt + 1;
      snap_ope   = OPE_L;
      snap_a     = A_L;
      snap_b     = B_L;
      snap_valid = VALID;
      snap_dirty = DIRTY;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic test_reset;
    RST_N = 1'b0; OPE_RAW = 2'b00; A_RAW = 4'h0; B_RAW = 4'h0;
    DISP_RAW = 2'b00; EXEC_RAW = 1'b0;
    #2;
    checks++;
    if ({LOAD, VALID, DIRTY, OPE_L, A_L, B_L, DISP} !== 15'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {LOAD, VALID, DIRTY, OPE_L, A_L, B_L, DISP});
    end
    cycles(3);
    RST_N = 1'b1;
    seen_valid = 1'b0; seen_dirty = 1'b0; load_cnt = 0;
    cycles(40);
    checks++;
    if (load_cnt !== 0 || seen_valid !== 1'b0 || seen_dirty !== 1'b0) begin
      errors++;
      $display("FAIL release_quiet: loads=%0d valid=%b dirty=%b expected 0/0/0",
               load_cnt, seen_valid, seen_dirty);
    end
  endtask

  task automatic test_capture;
    int base;
    OPE_RAW = 2'b10; A_RAW = 4'h7; B_RAW = 4'h3; DISP_RAW = 2'b11;
    cycles(30);
    checks++;
    if (DISP !== 2'b11) begin
      errors++;
      $display("FAIL disp_live: got %b expected 11", DISP);
    end
    base = load_cnt;
    EXEC_RAW = 1'b1;
    cycles(40);
    EXEC_RAW = 1'b0;
    cycles(30);
    checks++;
    if (load_cnt - base !== 1) begin
      errors++;
      $display("FAIL capture_one_load: got %0d expected 1", load_cnt - base);
    end
    checks++;
    if ({snap_ope, snap_a, snap_b} !== 10'b10_0111_0011) begin
      errors++;
      $display("FAIL capture_values: got ope=%0d a=%h b=%h expected 2 7 3",
               snap_ope, snap_a, snap_b);
    end
    checks++;
    if (snap_valid !== 1'b1 || snap_dirty !== 1'b0) begin
      errors++;
      $display("FAIL capture_flags: got valid=%b dirty=%b expected 1 0",
               snap_valid, snap_dirty);
    end
  endtask

  task automatic test_glitch;
    int base;
    seen_dirty = 1'b0;
    A_RAW = 4'hF;
    cycles(6);
    A_RAW = 4'h7;
    cycles(30);
    checks++;
    if (seen_dirty !== 1'b0 || A_L !== 4'h7) begin
      errors++;
      $display("FAIL glitch_a: got dirty_seen=%b a_l=%h expected 0 7", seen_dirty, A_L);
    end
    base = load_cnt;
    EXEC_RAW = 1'b1;
    cycles(6);
    EXEC_RAW = 1'b0;
    cycles(30);
    checks++;
    if (load_cnt - base !== 0) begin
      errors++;
      $display("FAIL glitch_exec: got %0d loads expected 0", load_cnt - base);
    end
  endtask

  task automatic test_dirty;
    int base;
    B_RAW = 4'h9;
    cycles(2);
    checks++;
    if (DIRTY !== 1'b0) begin
      errors++;
      $display("FAIL dirty_early: got %b expected 0", DIRTY);
    end
    cycles(28);
    checks++;
    if (DIRTY !== 1'b1 || B_L !== 4'h3) begin
      errors++;
      $display("FAIL dirty_rise: got dirty=%b b_l=%h expected 1 3", DIRTY, B_L);
    end
    base = load_cnt;
    EXEC_RAW = 1'b1;
    cycles(40);
    EXEC_RAW = 1'b0;
    cycles(30);
    checks++;
    if (load_cnt - base !== 1 || snap_b !== 4'h9 || snap_a !== 4'h7 || snap_dirty !== 1'b0) begin
      errors++;
      $display("FAIL recapture: got loads=%0d b=%h a=%h dirty=%b expected 1 9 7 0",
               load_cnt - base, snap_b, snap_a, snap_dirty);
    end
    checks++;
    if (DIRTY !== 1'b0) begin
      errors++;
      $display("FAIL dirty_clear: got %b expected 0", DIRTY);
    end
  endtask

  task automatic test_held_through_reset;
    int base;
    EXEC_RAW = 1'b1;
    cycles(2);
    RST_N = 1'b0;
    cycles(3);
    RST_N = 1'b1;
    base = load_cnt;
    seen_valid = 1'b0;
    cycles(50);
    checks++;
    if (load_cnt - base !== 0 || seen_valid !== 1'b0) begin
      errors++;
      $display("FAIL held_no_load: got loads=%0d valid_seen=%b expected 0 0",
               load_cnt - base, seen_valid);
    end
    EXEC_RAW = 1'b0;
    cycles(30);
    EXEC_RAW = 1'b1;
    cycles(40);
    checks++;
    if (load_cnt - base !== 1 || VALID !== 1'b1) begin
      errors++;
      $display("FAIL held_repress: got loads=%0d valid=%b expected 1 1",
               load_cnt - base, VALID);
    end
    checks++;
    if ({snap_ope, snap_a, snap_b} !== 10'b10_0111_1001) begin
      errors++;
      $display("FAIL held_values: got ope=%0d a=%h b=%h expected 2 7 9",
               snap_ope, snap_a, snap_b);
    end
  endtask

  task automatic test_async_reset;
    int  waited;
    logic hit;
    EXEC_RAW = 1'b0;
    cycles(30);
    EXEC_RAW = 1'b1;
    hit = 1'b0;
    waited = 0;
    while (!hit && waited < 60) begin
      @(negedge CLK);
      waited++;
      if (LOAD === 1'b1) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL async_wait_load: no LOAD within %0d cycles", waited);
    end else begin
      #2;
      RST_N = 1'b0;
      #1;
      checks++;
      if ({LOAD, VALID, OPE_L, A_L, B_L, DISP} !== 14'h0) begin
        errors++;
        $display("FAIL async_reset: got %b expected all zero",
                 {LOAD, VALID, OPE_L, A_L, B_L, DISP});
      end
    end
    cycles(2);
    RST_N = 1'b1;
  endtask

  initial begin
    test_reset();
    test_capture();
    test_glitch();
    test_dirty();
    test_held_through_reset();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
